// File: rtl/rng_req_arbiter.sv
// Round-robin arbiter that hands out words of a shared RNG stream, one word per grant.
// Owns re-seeding of the RNG core and its warm-up discard window.
module rng_req_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned WARMUP_CYCLES = 624,
    parameter logic [31:0] SEED_DEFAULT  = 32'd5489
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rnd_data,
    input  logic [31:0]        seed_in,
    input  logic               seed_load,
    output logic [31:0]        rng_seed,
    output logic               rng_re_seed,
    input  logic [31:0]        rng_rnd,
    output logic               busy,
    output logic [15:0]        grant_count
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        StReseed,
        StWarmup,
        StServe
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] last_gnt_q;
    logic [CNT_W-1:0] warm_cnt_q;

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [IDX_W:0]   cand;

    // Search upward from the requester after the last winner, wrapping at NUM_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_gnt_q;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_gnt_q} + (IDX_W + 1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!pick_valid && req[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StReseed;
            rng_seed    <= SEED_DEFAULT;
            last_gnt_q  <= LAST_IDX;
            warm_cnt_q  <= '0;
            gnt         <= '0;
            rnd_data    <= '0;
            rng_re_seed <= 1'b0;
            busy        <= 1'b1;
            grant_count <= '0;
        end else begin
            gnt         <= '0;
            rng_re_seed <= 1'b0;
            if (seed_load) begin
                rng_seed <= seed_in;
            end
            unique case (state_q)
                StReseed: begin
                    busy <= 1'b1;
                    // A fresh seed arriving here restarts RESEED so the strobe carries it.
                    if (!seed_load) begin
                        rng_re_seed <= 1'b1;
                        warm_cnt_q  <= WARM_LOAD;
                        state_q     <= StWarmup;
                    end
                end
                StWarmup: begin
                    if (seed_load) begin
                        state_q <= StReseed;
                        busy    <= 1'b1;
                    end else if (warm_cnt_q == '0) begin
                        state_q <= StServe;
                        busy    <= 1'b0;
                    end else begin
                        warm_cnt_q <= warm_cnt_q - 1'b1;
                        busy       <= 1'b1;
                    end
                end
                StServe: begin
                    if (seed_load) begin
                        state_q <= StReseed;
                        busy    <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                        if (pick_valid) begin
                            gnt[pick_idx] <= 1'b1;
                            rnd_data      <= rng_rnd;
                            last_gnt_q    <= pick_idx;
                            if (grant_count != 16'hFFFF) begin
                                grant_count <= grant_count + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= StReseed;
                    busy    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_req_arbiter.sv
// Scoreboard bench for rng_req_arbiter: directed stimulus queues expected grants,
// a negedge monitor pops and compares whenever a grant is presented.
module tb_rng_req_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  gnt;
    logic [31:0] rnd_data;
    logic [31:0] seed_in = '0;
    logic        seed_load = 1'b0;
    logic [31:0] rng_seed;
    logic        rng_re_seed;
    logic [31:0] rng_rnd = 32'h1111_0000;
    logic        busy;
    logic [15:0] grant_count;

    rng_req_arbiter #(
        .NUM_REQ      (4),
        .WARMUP_CYCLES(624),
        .SEED_DEFAULT (32'd5489)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .rnd_data   (rnd_data),
        .seed_in    (seed_in),
        .seed_load  (seed_load),
        .rng_seed   (rng_seed),
        .rng_re_seed(rng_re_seed),
        .rng_rnd    (rng_rnd),
        .busy       (busy),
        .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  gnt;
        logic [31:0] rnd;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] exp_count = '0;
    logic [31:0] last_rnd = '0;
    logic [3:0]  rr;
    logic [3:0]  seq[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && gnt != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("gnt", 32'(gnt), 32'(mon_e.gnt));
                check("rnd_data", rnd_data, mon_e.rnd);
                check("grant_count", 32'(grant_count), 32'(mon_e.cnt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        rng_rnd = 32'hC0DE_0000 ^ (32'(cyc) * 32'h0001_0003);
    endtask

    // Drive one cycle; eg is the grant expected from the edge that ends it.
    task automatic step(input logic [3:0] r, input logic sl, input logic [31:0] sv,
                        input logic [3:0] eg);
        req       = r;
        seed_load = sl;
        seed_in   = sv;
        if (eg != 4'b0000) begin
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            exp_q.push_back('{gnt: eg, rnd: rng_rnd, cnt: exp_count});
            last_rnd = rng_rnd;
        end
        tick();
    endtask

    // Called right after the re-seed strobe edge: expects 624 busy cycles then SERVE.
    task automatic warm_check(input logic [3:0] r, input string name);
        int bad;
        bad = 0;
        for (int k = 1; k <= 624; k++) begin
            if (busy !== 1'b1) bad++;
            step(r, 1'b0, 32'd0, 4'b0000);
        end
        check({name, "_busy_cycles_low"}, 32'(bad), 32'd0);
        check({name, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int bad;
        #1 rst_n = 1'b0;
        #10;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rnd", rnd_data, 32'd0);
        check("rst_re_seed", 32'(rng_re_seed), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_count", 32'(grant_count), 32'd0);
        check("rst_seed", rng_seed, 32'd5489);

        @(posedge clk);
        #1 rst_n = 1'b1;
        step(4'b1111, 1'b0, 32'd0, 4'b0000);
        check("init_re_seed", 32'(rng_re_seed), 32'd1);
        check("init_seed", rng_seed, 32'd5489);
        bad = 0;
        for (int k = 1; k <= 624; k++) begin
            if (busy !== 1'b1) bad++;
            step(4'b1111, 1'b0, 32'd0, 4'b0000);
            if (k == 1) check("init_re_seed_pulse", 32'(rng_re_seed), 32'd0);
        end
        check("init_busy_cycles_low", 32'(bad), 32'd0);
        check("init_busy_end", 32'(busy), 32'd0);

        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 32'd0, seq[i]);

        step(4'b0100, 1'b0, 32'd0, 4'b0100);
        step(4'b0000, 1'b0, 32'd0, 4'b0000);
        check("idle_rnd_hold", rnd_data, last_rnd);
        step(4'b0101, 1'b0, 32'd0, 4'b0001);
        step(4'b0101, 1'b0, 32'd0, 4'b0100);
        step(4'b0000, 1'b0, 32'd0, 4'b0000);

        step(4'b0010, 1'b1, 32'hDEAD_BEEF, 4'b0000);
        check("sl_serve_busy", 32'(busy), 32'd1);
        check("sl_serve_no_strobe", 32'(rng_re_seed), 32'd0);
        step(4'b0010, 1'b0, 32'd0, 4'b0000);
        check("sl_serve_re_seed", 32'(rng_re_seed), 32'd1);
        check("sl_serve_seed", rng_seed, 32'hDEAD_BEEF);
        warm_check(4'b0010, "sl_serve");
        step(4'b0010, 1'b0, 32'd0, 4'b0010);
        step(4'b0000, 1'b0, 32'd0, 4'b0000);

        step(4'b0000, 1'b1, 32'h1234_5678, 4'b0000);
        step(4'b0000, 1'b0, 32'd0, 4'b0000);
        check("sl_a_re_seed", 32'(rng_re_seed), 32'd1);
        check("sl_a_seed", rng_seed, 32'h1234_5678);
        for (int j = 0; j < 523; j++) step(4'b1000, 1'b0, 32'd0, 4'b0000);
        step(4'b1000, 1'b1, 32'hCAFE_F00D, 4'b0000);
        check("sl_warm_busy", 32'(busy), 32'd1);
        check("sl_warm_no_strobe", 32'(rng_re_seed), 32'd0);
        step(4'b1000, 1'b0, 32'd0, 4'b0000);
        check("sl_warm_re_seed", 32'(rng_re_seed), 32'd1);
        check("sl_warm_seed", rng_seed, 32'hCAFE_F00D);
        warm_check(4'b1000, "sl_warm");
        step(4'b1000, 1'b0, 32'd0, 4'b1000);

        rr = 4'b0001;
        while (exp_count != 16'hFFFF) begin
            step(4'b1111, 1'b0, 32'd0, rr);
            rr = {rr[2:0], rr[3]};
        end
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b0, 32'd0, rr);
            rr = {rr[2:0], rr[3]};
        end
        check("count_saturated", 32'(grant_count), 32'h0000_FFFF);

        step(4'b1111, 1'b0, 32'd0, rr);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'd0);
        check("async_rst_rnd", rnd_data, 32'd0);
        check("async_rst_count", 32'(grant_count), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd1);
        check("async_rst_seed", rng_seed, 32'd5489);
        check("pending_expectations", 32'(exp_q.size()), 32'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rng_req_arbiter.md
RNG_REQ_ARBITER -- requirements
Module: rng_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one RNG stream (2..8).
REQ-002 Parameter WARMUP_CYCLES, default 624, cycles discarded after each re-seed before grants resume (>=1).
REQ-003 Parameter SEED_DEFAULT, default 32'd5489, seed applied automatically after reset.
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: req  input  NUM_REQ  level request per requester; held until granted.
REQ-007 Port: gnt  output  NUM_REQ  registered one-hot grant, one-cycle pulse.
REQ-008 Port: rnd_data  output  32  registered random word for the granted requester; valid only while gnt != 0.
REQ-009 Port: seed_in  input  32  new seed value, sampled when seed_load=1.
REQ-010 Port: seed_load  input  1  one-cycle pulse requesting a re-seed.
REQ-011 Port: rng_seed  output  32  seed driven to the RNG core.
REQ-012 Port: rng_re_seed  output  1  registered one-cycle re-seed strobe to the RNG core.
REQ-013 Port: rng_rnd  input  32  RNG core output; core advances one word per cycle.
REQ-014 Port: busy  output  1  high in RESEED or WARMUP.
REQ-015 Port: grant_count  output  16  saturating count of grants since last reset.

Function
REQ-016 FSM states RESEED, WARMUP, SERVE; exactly one active per cycle.
REQ-017 RESEED: rng_re_seed=1 for exactly one cycle, rng_seed = latched seed; next state WARMUP.
REQ-018 WARMUP: down-counter loaded with WARMUP_CYCLES-1 on entry; decrements per cycle; WARMUP->SERVE on cycle after counter reaches 0 (WARMUP lasts exactly WARMUP_CYCLES cycles).
REQ-019 SERVE: when req != 0 in cycle t, gnt and rnd_data asserted in cycle t+1 (1-cycle latency); rnd_data = rng_rnd sampled in cycle t.
REQ-020 At most one grant per cycle; each rng_rnd word delivered to at most one requester.
REQ-021 Round-robin: search starts at index last_gnt+1 mod NUM_REQ, ascending with wrap; last_gnt updates only on a grant.
REQ-022 A requester whose req is still high the cycle after its grant is treated as a new request (no implicit hold).
REQ-023 req=0 in SERVE: gnt=0, rnd_data holds previous value, last_gnt unchanged.
REQ-024 No grants in RESEED or WARMUP; gnt=0; pending req wait, no loss.
REQ-025 seed_load in SERVE: seed_in latched; next state RESEED; any grant computed in that cycle is suppressed (gnt=0 next cycle).
REQ-026 seed_load in RESEED or WARMUP: seed_in latched, warm-up aborted, next state RESEED (restart).
REQ-027 grant_count increments by 1 per grant, saturates at 16'hFFFF, not cleared by re-seed.
REQ-028 busy = (state != SERVE), registered with state.

Reset
REQ-029 rst_n low asynchronously forces: state RESEED, latched seed = SEED_DEFAULT, last_gnt = NUM_REQ-1, gnt=0, rnd_data=0, rng_re_seed=0, warm-up counter=0, grant_count=0, busy=1.
REQ-030 First cycle after rst_n release executes RESEED (rng_re_seed=1, rng_seed=5489 default).
REQ-031 Reset asserted mid-warm-up or mid-grant clears all outputs in the same cycle, without waiting for clk.

Verification
REQ-032 Reset release, req=4'b1111, WARMUP_CYCLES=624 -> rng_re_seed pulse cycle 1, busy=1 for 625 cycles, first gnt=4'b0001 on cycle after SERVE entry.
REQ-033 SERVE, req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; rnd_data equals rng_rnd of preceding cycle each time.
REQ-034 SERVE, last_gnt=2, req=4'b0101 -> gnt=0100? no: gnt=4'b0001 (index 0, wrap from 3), then 4'b0100.
REQ-035 seed_load with seed_in=32'hDEADBEEF in SERVE while req=4'b0010 -> no gnt next cycle, rng_re_seed=1 with rng_seed=32'hDEADBEEF, gnt resumes after 624 WARMUP cycles.
REQ-036 seed_load at WARMUP count 100 -> RESEED restarts, full 624-cycle warm-up re-executed.
REQ-037 grant_count preset near 16'hFFFE, 3 grants -> grant_count stays 16'hFFFF.
